// File: rtl/lap_stop_watch.sv
// Lap stopwatch: run/stop/idle control, tick prescaler, h:m:s.cs cascade and
// a first-word-fall-through lap FIFO with a sticky overflow flag.
// Handshake: run, clear, lap and lap_rd are single-cycle request pulses with
// no ready; each is acted on at the edge where it is high, or dropped when the
// current state does not accept it.
module lap_stop_watch #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int SEC_MAX   = 60,
  parameter int HOUR_MAX  = 24,
  parameter int LAP_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sw_mode,
  input  logic                          run,
  input  logic                          clear,
  input  logic                          lap,
  input  logic                          lap_rd,
  output logic [$clog2(TICK_HZ)-1:0]    msec,
  output logic [$clog2(SEC_MAX)-1:0]    sec,
  output logic [$clog2(SEC_MAX)-1:0]    min,
  output logic [$clog2(HOUR_MAX)-1:0]   hour,
  output logic                          tick,
  output logic                          running,
  output logic [$clog2(TICK_HZ)-1:0]    lap_msec,
  output logic [$clog2(SEC_MAX)-1:0]    lap_sec,
  output logic [$clog2(SEC_MAX)-1:0]    lap_min,
  output logic [$clog2(HOUR_MAX)-1:0]   lap_hour,
  output logic [$clog2(LAP_DEPTH):0]    lap_count,
  output logic                          lap_empty,
  output logic                          lap_full,
  output logic                          lap_ovf,
  output logic                          rollover,
  output logic [1:0]                    state_dbg
);

  localparam int PRESC = CLK_FREQ / TICK_HZ;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int MW    = $clog2(TICK_HZ);
  localparam int SW    = $clog2(SEC_MAX);
  localparam int HW    = $clog2(HOUR_MAX);
  localparam int AW    = $clog2(LAP_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = MW + 2 * SW + HW;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [MW-1:0] MSEC_LAST  = MW'(TICK_HZ - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_MAX - 1);
  localparam logic [HW-1:0] HOUR_LAST  = HW'(HOUR_MAX - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   presc;
  logic [EW-1:0]   mem [LAP_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [EW-1:0]   head;

  logic ctl_run, ctl_clear, enter_idle;
  logic presc_wrap, msec_wrap, sec_wrap, min_wrap, hour_wrap;
  logic lap_req, do_pop, do_push, ovf_set;

  // watch mode masks the control buttons but never the lap read
  assign ctl_run   = run & ~sw_mode;
  assign ctl_clear = clear & ~sw_mode;
  assign state_dbg = state;

  // next-state decode; run beats clear in STOP
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ctl_run) state_nxt = S_RUN;
      S_RUN:   if (ctl_run) state_nxt = S_STOP;
      S_STOP: begin
        if (ctl_run)        state_nxt = S_RUN;
        else if (ctl_clear) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_idle = (state == S_STOP) && (state_nxt == S_IDLE);

  // control FSM with registered running flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == S_RUN);
    end
  end

  assign presc_wrap = (state == S_RUN) && (presc == PRESC_LAST);
  assign msec_wrap  = presc_wrap && (msec == MSEC_LAST);
  assign sec_wrap   = msec_wrap && (sec == SEC_LAST);
  assign min_wrap   = sec_wrap && (min == SEC_LAST);
  assign hour_wrap  = min_wrap && (hour == HOUR_LAST);

  // prescaler and time cascade; tick/rollover are one-cycle strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      msec     <= '0;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      tick     <= 1'b0;
      rollover <= 1'b0;
    end else begin
      tick     <= 1'b0;
      rollover <= 1'b0;
      if (enter_idle) begin
        presc <= '0;
        msec  <= '0;
        sec   <= '0;
        min   <= '0;
        hour  <= '0;
      end else if (state == S_RUN) begin
        if (presc_wrap) begin
          presc    <= '0;
          tick     <= 1'b1;
          rollover <= hour_wrap;
          msec     <= msec_wrap ? '0 : msec + MW'(1);
          if (msec_wrap) sec  <= sec_wrap  ? '0 : sec + SW'(1);
          if (sec_wrap)  min  <= min_wrap  ? '0 : min + SW'(1);
          if (min_wrap)  hour <= hour_wrap ? '0 : hour + HW'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  // lap FIFO control: a full FIFO still accepts a push when the head pops
  assign lap_req = lap & ~sw_mode & (state != S_IDLE);
  assign do_pop  = lap_rd && (lap_count != '0);
  assign do_push = lap_req && ((lap_count != DEPTH_C) || do_pop);
  assign ovf_set = lap_req && (lap_count == DEPTH_C) && !do_pop;

  // FIFO pointers, occupancy and sticky overflow; IDLE entry flushes all
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
      lap_ovf   <= 1'b0;
    end else if (enter_idle) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
      lap_ovf   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   lap_count <= lap_count + CW'(1);
        2'b01:   lap_count <= lap_count - CW'(1);
        default: lap_count <= lap_count;
      endcase
      if (ovf_set) lap_ovf <= 1'b1;
    end
  end

  // lap storage captures the pre-edge field values
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {hour, min, sec, msec};
  end

  assign head      = mem[rd_ptr];
  assign lap_empty = (lap_count == '0);
  assign lap_full  = (lap_count == DEPTH_C);
  assign lap_msec  = lap_empty ? '0 : head[MW-1:0];
  assign lap_sec   = lap_empty ? '0 : head[MW+SW-1:MW];
  assign lap_min   = lap_empty ? '0 : head[MW+2*SW-1:MW+SW];
  assign lap_hour  = lap_empty ? '0 : head[EW-1:MW+2*SW];

endmodule

// File: tb/tb_lap_stop_watch.sv
// Bench for lap_stop_watch: reference model keeps elapsed run cycles and a
// queue of captured times; fields are derived from them arithmetically.
module tb_lap_stop_watch;

  localparam int CLK_FREQ  = 1000;
  localparam int TICK_HZ   = 100;
  localparam int SEC_MAX   = 3;
  localparam int HOUR_MAX  = 3;
  localparam int LAP_DEPTH = 4;
  localparam int PRESC     = CLK_FREQ / TICK_HZ;
  localparam int TOTAL     = TICK_HZ * SEC_MAX * SEC_MAX * HOUR_MAX;
  localparam int MW = $clog2(TICK_HZ);
  localparam int SW = $clog2(SEC_MAX);
  localparam int HW = $clog2(HOUR_MAX);
  localparam int CW = $clog2(LAP_DEPTH) + 1;
  localparam int EW = MW + 2 * SW + HW;

  logic clk, reset, sw_mode, run, clear, lap, lap_rd;
  logic [MW-1:0] msec, lap_msec;
  logic [SW-1:0] sec, min, lap_sec, lap_min;
  logic [HW-1:0] hour, lap_hour;
  logic [CW-1:0] lap_count;
  logic tick, running, lap_empty, lap_full, lap_ovf, rollover;
  logic [1:0] state_dbg;

  lap_stop_watch #(
    .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .SEC_MAX(SEC_MAX),
    .HOUR_MAX(HOUR_MAX), .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .sw_mode(sw_mode), .run(run), .clear(clear),
    .lap(lap), .lap_rd(lap_rd), .msec(msec), .sec(sec), .min(min),
    .hour(hour), .tick(tick), .running(running), .lap_msec(lap_msec),
    .lap_sec(lap_sec), .lap_min(lap_min), .lap_hour(lap_hour),
    .lap_count(lap_count), .lap_empty(lap_empty), .lap_full(lap_full),
    .lap_ovf(lap_ovf), .rollover(rollover), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int m_st;       // 0 idle, 1 run, 2 stop
  int m_elapsed;  // clock edges spent in RUN since last IDLE
  logic m_tick, m_roll, m_ovf;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int cur_t();
    return (m_elapsed / PRESC) % TOTAL;
  endfunction

  function automatic logic [EW-1:0] tm(input int t);
    logic [MW-1:0] ms;
    logic [SW-1:0] s, m;
    logic [HW-1:0] h;
    ms = MW'(t % TICK_HZ);
    s  = SW'((t / TICK_HZ) % SEC_MAX);
    m  = SW'((t / (TICK_HZ * SEC_MAX)) % SEC_MAX);
    h  = HW'((t / (TICK_HZ * SEC_MAX * SEC_MAX)) % HOUR_MAX);
    return {h, m, s, ms};
  endfunction

  task automatic model_reset();
    m_st = 0; m_elapsed = 0; m_tick = 0; m_roll = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic r, c, l, rd, sm);
    int ns;
    logic acc, pop;
    logic [EW-1:0] cap;
    cap = tm(cur_t());
    ns = m_st;
    if (!sm && r)                  ns = (m_st == 1) ? 2 : 1;
    else if (!sm && c && m_st == 2) ns = 0;
    acc = !sm && l && (m_st != 0);
    pop = rd && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      if (exp_q.size() < LAP_DEPTH) exp_q.push_back(cap);
      else m_ovf = 1'b1;
    end
    if (m_st == 1) begin
      m_elapsed++;
      m_tick = (m_elapsed % PRESC == 0);
      m_roll = m_tick && ((m_elapsed / PRESC) % TOTAL == 0);
    end else begin
      m_tick = 1'b0;
      m_roll = 1'b0;
    end
    if (m_st == 2 && ns == 0) begin
      m_elapsed = 0;
      exp_q.delete();
      m_ovf = 1'b0;
    end
    m_st = ns;
  endtask

  task automatic compare_all();
    logic [EW-1:0] hd;
    logic [63:0] e, a;
    hd = (exp_q.size() > 0) ? exp_q[0] : '0;
    e = {tm(cur_t()), hd, m_tick, (m_st == 1), CW'(exp_q.size()),
         (exp_q.size() == 0), (exp_q.size() == LAP_DEPTH), m_ovf, m_roll};
    a = {hour, min, sec, msec, lap_hour, lap_min, lap_sec, lap_msec, tick,
         running, lap_count, lap_empty, lap_full, lap_ovf, rollover};
    chk("outputs", a, e);
  endtask

  // driver: called at a negedge, applies one cycle of inputs
  task automatic step(input logic r, c, l, rd, sm);
    run = r; clear = c; lap = l; lap_rd = rd; sw_mode = sm;
    @(posedge clk);
    model_edge(r, c, l, rd, sm);
    @(negedge clk);
    run = 0; clear = 0; lap = 0; lap_rd = 0; sw_mode = 0;
    compare_all();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_fields"}, {hour, min, sec, msec}, 0);
    chk({nm, "_flags"}, {tick, running, lap_count, lap_full, lap_ovf, rollover}, 0);
    chk({nm, "_head"}, {lap_hour, lap_min, lap_sec, lap_msec}, 0);
    chk({nm, "_empty"}, lap_empty, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1 check_zero("reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_all();
  endtask

  typedef struct {
    logic r, c, l, rd, sm;
    logic exp_running;
    int   exp_count;
  } vec_t;

  vec_t tbl[15];
  logic [EW-1:0] lapv[6];

  initial begin
    int first_tick, nticks, rc, tk, n;
    logic [EW-1:0] at_roll;

    tbl[0]  = '{0, 0, 1, 0, 0, 0, 0};  // lap in IDLE ignored
    tbl[1]  = '{0, 0, 0, 1, 0, 0, 0};  // pop on empty
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0};  // clear in IDLE
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 0};  // run masked by sw_mode
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 0};  // IDLE -> RUN
    tbl[5]  = '{0, 0, 1, 0, 0, 1, 1};  // lap in RUN
    tbl[6]  = '{0, 0, 1, 0, 1, 1, 1};  // lap masked by sw_mode
    tbl[7]  = '{0, 0, 0, 1, 1, 1, 0};  // pop honoured in sw_mode
    tbl[8]  = '{0, 1, 0, 0, 0, 1, 0};  // clear ignored in RUN
    tbl[9]  = '{1, 0, 0, 0, 1, 1, 0};  // stop masked by sw_mode
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0};  // RUN -> STOP
    tbl[11] = '{0, 0, 1, 0, 0, 0, 1};  // lap in STOP
    tbl[12] = '{1, 1, 0, 0, 0, 1, 1};  // run beats clear
    tbl[13] = '{1, 0, 0, 0, 0, 0, 1};  // RUN -> STOP
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0};  // STOP -> IDLE flushes

    run = 0; clear = 0; lap = 0; lap_rd = 0; sw_mode = 0; reset = 1'b1;
    @(negedge clk);
    do_reset();

    // table-driven control vectors
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].rd, tbl[i].sm);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].exp_running);
      chk($sformatf("tbl%0d_count", i), lap_count, tbl[i].exp_count);
    end

    // counting from IDLE: tick every PRESC clocks
    step(1, 0, 0, 0, 0);
    first_tick = -1; nticks = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(0, 0, 0, 0, 0);
      if (tick) begin
        nticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    chk("first_tick", first_tick, 10);
    chk("ticks_1000", nticks, 100);
    chk("t1000_msec", msec, 0);
    chk("t1000_sec", sec, 1);
    chk("t1000_running", running, 1);

    // stop at 2.37 with prescaler mid-count, hold, restart
    nops(1374);
    step(1, 0, 0, 0, 0);
    chk("stop_sec", sec, 2);
    chk("stop_msec", msec, 37);
    nops(500);
    chk("hold_sec", sec, 2);
    chk("hold_msec", msec, 37);
    chk("hold_running", running, 0);
    step(1, 0, 0, 0, 0);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step(0, 0, 0, 0, 0);
      if (tick) n = i;
    end
    chk("restart_tick_delay", n, 5);
    chk("restart_msec", msec, 38);

    // five laps into a 4-deep FIFO
    for (int k = 0; k < 5; k++) begin
      nops(19);
      lapv[k] = tm(cur_t());
      step(0, 0, 1, 0, 0);
    end
    chk("laps_full", lap_full, 1);
    chk("laps_ovf", lap_ovf, 1);
    chk("laps_count", lap_count, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pop%0d_head", k), {lap_hour, lap_min, lap_sec, lap_msec}, lapv[k]);
      step(0, 0, 0, 1, 0);
    end
    chk("drained_empty", lap_empty, 1);
    step(0, 0, 0, 1, 0);
    chk("rd_empty_count", lap_count, 0);
    chk("rd_empty_head", {lap_hour, lap_min, lap_sec, lap_msec}, 0);

    // flush, then simultaneous push/pop on a full FIFO
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("flush_ovf", lap_ovf, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      nops(14);
      lapv[k] = tm(cur_t());
      step(0, 0, 1, 0, 0);
    end
    chk("refill_full", lap_full, 1);
    nops(14);
    lapv[4] = tm(cur_t());
    step(0, 0, 1, 1, 0);
    chk("pushpop_count", lap_count, 4);
    chk("pushpop_ovf", lap_ovf, 0);
    chk("pushpop_head", {lap_hour, lap_min, lap_sec, lap_msec}, lapv[1]);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("pushpop_tail", {lap_hour, lap_min, lap_sec, lap_msec}, lapv[4]);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("clear_count", lap_count, 0);
    chk("clear_ovf", lap_ovf, 0);
    chk("clear_fields", {hour, min, sec, msec}, 0);
    chk("clear_running", running, 0);

    // full-scale rollover
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("clear_in_run", running, 1);
    while (m_elapsed < (TOTAL - 2) * PRESC) step(0, 0, 0, 0, 0);
    chk("preroll_time", {hour, min, sec, msec}, {2'd2, 2'd2, 2'd2, 7'd98});
    rc = 0; tk = 0; at_roll = '1;
    for (int i = 0; i < 40 && tk < 2; i++) begin
      step(0, 0, 0, 0, 0);
      if (tick) tk++;
      if (rollover) begin
        rc++;
        at_roll = {hour, min, sec, msec};
      end
    end
    chk("roll_ticks", tk, 2);
    chk("roll_fields", at_roll, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      if (rollover) rc++;
    end
    chk("roll_pulses", rc, 1);

    // watch mode: control masked, counting continues
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1);
    chk("sw_running", running, 1);
    chk("sw_count", lap_count, 0);
    tk = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 0, 1);
      if (tick) tk++;
    end
    chk("sw_ticks", tk, 2);
    chk("sw_no_laps", lap_empty, 1);

    // asynchronous reset mid-count
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_all();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
